// File: rtl/hazard_pkg.sv
// Shared register-file geometry and scoreboard defaults for the hazard unit.
package hazard_pkg;

   localparam int REG_ADDR_W          = 5;
   localparam int NUM_REGS            = 32;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter; simultaneous inc and dec cancel out.
module sb_counter #(
   parameter int MAX = 4,
   parameter int W   = $clog2(MAX+1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != MAX_C))
         count_d = count_q + W'(1);
      else if (dec_i && !inc_i && (count_q != '0))
         count_d = count_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/scoreboard_unit.sv
// Long-latency write scoreboard: tracks pending destination registers and
// raises decode stalls / execute flushes for RAW, WAW and tracker-full hazards.
module scoreboard_unit
   import hazard_pkg::*;
#(
   parameter int  MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
   localparam int CNT_W           = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_D,
   input  reg_addr_t           rs1_D,
   input  reg_addr_t           rs2_D,
   input  reg_addr_t           rd_D,
   input  logic                regwrite_D,
   input  logic                long_D,
   input  logic                ready_valid,
   input  reg_addr_t           ready_rd,
   input  logic                pcsrc_E,
   output logic                stall_F,
   output logic                stall_D,
   output logic                flush_D,
   output logic                flush_E,
   output logic [NUM_REGS-1:0] pending,
   output logic [CNT_W-1:0]    outstanding
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic                clr_eff;
   logic                rs1_haz, rs2_haz, waw_haz, full_haz;
   logic                hazard_D, stall, issue;
   logic [CNT_W-1:0]    cnt_after_clr;

   always_comb begin
      clr_eff = ready_valid && (ready_rd != '0) && pending_q[ready_rd];

      // A result that becomes ready this cycle is forwardable next cycle, so it
      // releases a reader now.
      rs1_haz = (rs1_D != '0) && pending_q[rs1_D] && !(ready_valid && (ready_rd == rs1_D));
      rs2_haz = (rs2_D != '0) && pending_q[rs2_D] && !(ready_valid && (ready_rd == rs2_D));
      waw_haz = regwrite_D && (rd_D != '0) && pending_q[rd_D] && !(clr_eff && (ready_rd == rd_D));

      cnt_after_clr = outstanding - CNT_W'(clr_eff);
      full_haz      = long_D && regwrite_D && (rd_D != '0) && (cnt_after_clr == MAX_C);

      hazard_D = valid_D && (rs1_haz || rs2_haz || waw_haz || full_haz);
      stall    = hazard_D && !pcsrc_E;
      issue    = valid_D && regwrite_D && long_D && (rd_D != '0) && !stall && !pcsrc_E;

      // Set is applied after clear so a same-register retire/reissue stays pending.
      pending_d = pending_q;
      if (clr_eff) pending_d[ready_rd] = 1'b0;
      if (issue)   pending_d[rd_D]     = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) pending_q <= '0;
      else       pending_q <= pending_d;
   end

   sb_counter #(
      .MAX (MAX_OUTSTANDING),
      .W   (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (issue),
      .dec_i   (clr_eff),
      .count_o (outstanding)
   );

   assign stall_F = stall;
   assign stall_D = stall;
   assign flush_D = pcsrc_E;
   assign flush_E = pcsrc_E || hazard_D;
   assign pending = pending_q;

endmodule

// File: tb/tb_scoreboard_unit.sv
// Self-checking bench for scoreboard_unit: directed scenarios plus random
// traffic, with expected pending/outstanding queued per driven cycle.
module tb_scoreboard_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_D;
   logic [4:0]  rs1_D, rs2_D, rd_D;
   logic        regwrite_D, long_D;
   logic        ready_valid;
   logic [4:0]  ready_rd;
   logic        pcsrc_E;
   logic        stall_F, stall_D, flush_D, flush_E;
   logic [31:0] pending;
   logic [2:0]  outstanding;

   typedef struct packed {
      logic [31:0] pend;
      logic [2:0]  cnt;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pend;
   int          m_cnt;
   int          n_chk  = 0;
   int          n_pass = 0;

   scoreboard_unit dut (
      .clk         (clk),
      .reset       (reset),
      .valid_D     (valid_D),
      .rs1_D       (rs1_D),
      .rs2_D       (rs2_D),
      .rd_D        (rd_D),
      .regwrite_D  (regwrite_D),
      .long_D      (long_D),
      .ready_valid (ready_valid),
      .ready_rd    (ready_rd),
      .pcsrc_E     (pcsrc_E),
      .stall_F     (stall_F),
      .stall_D     (stall_D),
      .flush_D     (flush_D),
      .flush_E     (flush_E),
      .pending     (pending),
      .outstanding (outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Drive one decode cycle, check combinational outputs against the model and
   // queue the state expected after the next edge.
   task automatic drive(input bit rst, input bit v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit rw, input bit lg, input bit rv,
                        input logic [4:0] rrd, input bit pc);
      bit clr, h1, h2, hw, hf, haz, iss;
      reset = rst; valid_D = v; rs1_D = r1; rs2_D = r2; rd_D = rd;
      regwrite_D = rw; long_D = lg; ready_valid = rv; ready_rd = rrd; pcsrc_E = pc;
      #1;
      clr = rv && (rrd != 0) && m_pend[rrd];
      h1  = (r1 != 0) && m_pend[r1] && !(rv && (rrd == r1));
      h2  = (r2 != 0) && m_pend[r2] && !(rv && (rrd == r2));
      hw  = rw && (rd != 0) && m_pend[rd] && !(clr && (rrd == rd));
      hf  = lg && rw && (rd != 0) && ((m_cnt - int'(clr)) == 4);
      haz = v && (h1 || h2 || hw || hf);
      iss = v && rw && lg && (rd != 0) && !haz && !pc;
      chk("stall_F", stall_F, haz && !pc);
      chk("stall_D", stall_D, haz && !pc);
      chk("flush_D", flush_D, pc);
      chk("flush_E", flush_E, pc || haz);
      if (rst) begin
         m_pend = '0;
         m_cnt  = 0;
      end else begin
         if (clr) begin m_pend[rrd] = 1'b0; m_cnt--; end
         if (iss) begin m_pend[rd]  = 1'b1; m_cnt++; end
      end
      exp_q.push_back({m_pend, 3'(m_cnt)});
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("pending", pending, e.pend);
         chk("outstanding", {29'd0, outstanding}, {29'd0, e.cnt});
      end
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; valid_D = 0; rs1_D = 0; rs2_D = 0; rd_D = 0; regwrite_D = 0;
      long_D = 0; ready_valid = 0; ready_rd = 0; pcsrc_E = 0;
      repeat (2) @(posedge clk);
      #1;
      m_pend = '0;
      m_cnt  = 0;
      chk("rst_pend", pending, 32'h0);
      chk("rst_out", {29'd0, outstanding}, 32'd0);

      // reset still held: branch flush passes through, ready ignored
      drive(1, 1, 5, 0, 6, 1, 1, 1, 3, 1);
      chk("rst_flushE", flush_E, 1);
      chk("rst_stall", stall_D, 0);
      tick();

      // load-use on x5
      drive(0, 1, 0, 0, 5, 1, 1, 0, 0, 0); tick();
      chk("lu_set", pending[5], 1);
      drive(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_stall", stall_D, 1);
      chk("lu_flushE", flush_E, 1);
      tick();
      drive(0, 1, 5, 0, 0, 0, 0, 1, 5, 0);
      chk("lu_go", stall_D, 0);
      tick();
      chk("lu_clr", pending[5], 0);

      // register 0 never tracked
      drive(0, 1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("r0_stall", stall_D, 0);
      tick();
      chk("r0_pend", pending, 32'h0);
      chk("r0_out", {29'd0, outstanding}, 32'd0);

      // saturation at four outstanding
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 0, 0, 5'(i), 1, 1, 0, 0, 0); tick();
      end
      drive(0, 1, 0, 0, 6, 1, 1, 0, 0, 0);
      chk("sat_stall", stall_D, 1);
      chk("sat_out", {29'd0, outstanding}, 32'd4);
      tick();
      drive(0, 1, 0, 0, 6, 1, 1, 1, 2, 0);
      chk("sat_go", stall_D, 0);
      tick();
      chk("sat_out2", {29'd0, outstanding}, 32'd4);
      chk("sat_pend", pending, 32'h0000_005A);

      // branch beats hazard, no scoreboard update
      drive(0, 1, 1, 0, 8, 1, 1, 0, 0, 1);
      chk("br_stall", stall_D, 0);
      chk("br_flushD", flush_D, 1);
      chk("br_flushE", flush_E, 1);
      tick();
      chk("br_pend", pending, 32'h0000_005A);

      // non-long write leaves scoreboard alone
      drive(0, 1, 0, 0, 12, 1, 0, 0, 0, 0); tick();
      chk("nl_pend", pending, 32'h0000_005A);

      // drain, plus a ready for a register that is not pending
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 3, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); tick();
      chk("drain_pend", pending, 32'h0);

      // same-register retire and reissue
      drive(0, 1, 0, 0, 7, 1, 1, 0, 0, 0); tick();
      drive(0, 1, 0, 0, 7, 1, 1, 1, 7, 0);
      chk("ss_stall", stall_D, 0);
      tick();
      chk("ss_bit", pending[7], 1);
      chk("ss_out", {29'd0, outstanding}, 32'd1);

      // reset mid-operation, then a stale ready
      drive(0, 1, 0, 0, 9, 1, 1, 0, 0, 0); tick();
      drive(0, 1, 0, 0, 10, 1, 1, 0, 0, 0); tick();
      chk("rm_pre", pending, 32'h0000_0680);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("rm_pend", pending, 32'h0);
      chk("rm_out", {29'd0, outstanding}, 32'd0);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); tick();
      chk("stale_pend", pending, 32'h0);
      chk("stale_out", {29'd0, outstanding}, 32'd0);

      // random traffic on a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
               $urandom_range(0, 9) == 0);
         tick();
      end
      idle(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
